// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST response analyzer and MISR.
//   state_t      - analyzer FSM states
//   DEF_POLY     - default MISR feedback polynomial
//   DEF_SIG_INIT - default MISR seed
//   cnt_width()  - bits needed to count 0..n inclusive
package bist_pkg;
    typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;
    localparam logic [15:0] DEF_POLY     = 16'h1021;
    localparam logic [15:0] DEF_SIG_INIT = 16'h0000;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/bist_resp_analyzer_if.sv
// bist_resp_analyzer_if: response/control bundle between a BIST controller (master) and the analyzer (slave).
//   start, resp_valid, resp_data, golden_sig - master to slave
//   busy, done, pass, signature, pat_count   - slave to master
interface bist_resp_analyzer_if
    import bist_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIG_W = 16,
    parameter int CNT_W = cnt_width(256)
);
    logic             start;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic [SIG_W-1:0] golden_sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] pat_count;
    modport master (output start, resp_valid, resp_data, golden_sig,
                    input  busy, done, pass, signature, pat_count);
    modport slave  (input  start, resp_valid, resp_data, golden_sig,
                    output busy, done, pass, signature, pat_count);
endinterface

// File: rtl/misr_reg.sv
// misr_reg: multiple-input signature register with seed load and enable (din tied to 0 gives a plain LFSR).
//   clk, rst - clock, async active-high reset (loads SEED)
//   load     - reload SEED (wins over en)
//   en       - advance one step, folding din into the register
//   din      - parallel input, zero-extended to SIG_W
//   q        - register contents
module misr_reg #(
    parameter int               WIDTH = 8,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [SIG_W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst)       q <= SEED;
        else if (load) q <= SEED;
        else if (en)   q <= {q[SIG_W-2:0], 1'b0} ^ (q[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
endmodule

// File: rtl/bist_resp_analyzer.sv
// bist_resp_analyzer: compacts PAT_CNT valid responses into a MISR signature and compares it with a golden value.
//   clk, rst - clock, async active-high reset
//   bus      - slave side: start/resp_valid/resp_data/golden_sig in; busy/done/pass/signature/pat_count out
module bist_resp_analyzer
    import bist_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SIG_INIT = SIG_W'(DEF_SIG_INIT),
    parameter int               PAT_CNT  = 256
) (
    input logic                  clk,
    input logic                  rst,
    bist_resp_analyzer_if.slave  bus
);
    localparam int CNT_W = cnt_width(PAT_CNT);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [SIG_W-1:0] sig;
    logic             pass_q;
    logic             take, last, load;
    assign take = state == COMPACT && bus.resp_valid;
    assign last = take && cnt == CNT_W'(PAT_CNT - 1);
    assign load = bus.start && (state == IDLE || state == DONE);
    misr_reg #(.WIDTH(WIDTH), .SIG_W(SIG_W), .POLY(POLY), .SEED(SIG_INIT)) u_misr (
        .clk(clk), .rst(rst), .load(load), .en(take), .din(bus.resp_data), .q(sig)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb
        state_nx = load ? COMPACT : last ? COMPARE : state == COMPARE ? DONE : state;
    // pass is cleared on restart so a stale result never survives into a new run
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt    <= '0;
            pass_q <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            pass_q <= 1'b0;
        end else begin
            if (take)             cnt    <= cnt + 1'b1;
            if (state == COMPARE) pass_q <= sig == bus.golden_sig;
        end
    always_comb begin
        bus.busy = state == COMPACT || state == COMPARE;
        bus.done = state == DONE;
    end
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.pat_count = cnt;
endmodule

// File: tb/tb_bist_resp_analyzer.sv
// tb_bist_resp_analyzer: scoreboard bench over four analyzer configurations driven with directed vectors.
module tb_bist_resp_analyzer;
    import bist_pkg::*;
    localparam int N = 4;
    localparam int          PC [N] = '{1, 2, 1, 4};
    localparam logic [15:0] SI [N] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000};
    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          cnt;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        start [N];
    logic        rv    [N];
    logic [7:0]  rd    [N];
    logic [15:0] gold  [N];
    logic        busy_w [N];
    logic        done_w [N];
    logic        pass_w [N];
    logic [15:0] sig_w  [N];
    int          cnt_w  [N];
    exp_t        q [N][$];
    int          checks = 0;
    int          failures = 0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    for (genvar g = 0; g < N; g++) begin : u
        bist_resp_analyzer_if #(.WIDTH(8), .SIG_W(16), .CNT_W(cnt_width(PC[g]))) bus ();
        bist_resp_analyzer #(
            .WIDTH(8), .SIG_W(16), .POLY(16'h1021), .SIG_INIT(SI[g]), .PAT_CNT(PC[g])
        ) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.start      = start[g];
        assign bus.resp_valid = rv[g];
        assign bus.resp_data  = rd[g];
        assign bus.golden_sig = gold[g];
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign pass_w[g] = bus.pass;
        assign sig_w[g]  = bus.signature;
        assign cnt_w[g]  = 32'(bus.pat_count);
        logic dprev = 1'b0;
        exp_t e;
        always @(negedge clk) begin
            if (done_w[g] && !dprev) begin
                if (q[g].size() == 0) chk($sformatf("unexpected_done%0d", g), 1, 0);
                else begin
                    e = q[g].pop_front();
                    chk($sformatf("sig%0d", g), sig_w[g], e.sig);
                    chk($sformatf("pass%0d", g), pass_w[g], e.pass);
                    chk($sformatf("count%0d", g), cnt_w[g], e.cnt);
                end
            end
            dprev = done_w[g];
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask
    task automatic send(input int i, input logic [7:0] d);
        rv[i] = 1'b1;
        rd[i] = d;
        tick();
        rv[i] = 1'b0;
    endtask
    task automatic wait_done(input int i);
        int n = 0;
        while (!done_w[i] && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("done_timeout%0d", i), done_w[i], 1);
    endtask
    task automatic push(input int i, input logic [15:0] s, input logic p, input int c);
        exp_t e;
        e.sig = s;
        e.pass = p;
        e.cnt = c;
        q[i].push_back(e);
    endtask
    initial begin
        logic [7:0] d1 [4] = '{8'h01, 8'h80, 8'hff, 8'h10};
        logic [7:0] d2 [4] = '{8'ha5, 8'h5a, 8'hc3, 8'h3c};
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0;
            rv[i] = 1'b0;
            rd[i] = 8'h00;
            gold[i] = 16'h0000;
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < N; i++) begin
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
            chk("rst_pass", pass_w[i], 0);
            chk("rst_sig", sig_w[i], SI[i]);
            chk("rst_count", cnt_w[i], 0);
        end
        // single pattern, exact latency, start in COMPARE ignored
        gold[0] = 16'h0001;
        push(0, 16'h0001, 1'b1, 1);
        pulse_start(0);
        chk("a_busy", busy_w[0], 1);
        send(0, 8'h01);
        chk("a_compare_done", done_w[0], 0);
        chk("a_compare_busy", busy_w[0], 1);
        chk("a_sig", sig_w[0], 16'h0001);
        pulse_start(0);
        chk("a_latency_done", done_w[0], 1);
        chk("a_start_in_compare", busy_w[0], 0);
        // start with resp_valid in IDLE: response must not be compacted; golden mismatch
        gold[1] = 16'h0003;
        push(1, 16'h0002, 1'b0, 2);
        start[1] = 1'b1;
        rv[1] = 1'b1;
        rd[1] = 8'hff;
        tick();
        start[1] = 1'b0;
        rv[1] = 1'b0;
        chk("b_count_after_start", cnt_w[1], 0);
        chk("b_sig_after_start", sig_w[1], 16'h0000);
        send(1, 8'h01);
        send(1, 8'h00);
        wait_done(1);
        // MSB feedback from a 0x8000 seed
        gold[2] = 16'h1021;
        push(2, 16'h1021, 1'b1, 1);
        pulse_start(2);
        send(2, 8'h00);
        wait_done(2);
        // resp_valid in IDLE ignored
        rv[3] = 1'b1;
        rd[3] = 8'h5a;
        tick();
        rv[3] = 1'b0;
        chk("d_idle_sig", sig_w[3], 16'h0000);
        chk("d_idle_count", cnt_w[3], 0);
        // gap-free run with start pulsed during COMPACT
        gold[3] = 16'h03e6;
        push(3, 16'h03e6, 1'b1, 4);
        pulse_start(3);
        send(3, d1[0]);
        pulse_start(3);
        chk("d_start_in_compact", cnt_w[3], 1);
        for (int k = 1; k < 4; k++) send(3, d1[k]);
        wait_done(3);
        // restart from DONE, then same data with 0..3 idle cycles between responses
        push(3, 16'h03e6, 1'b1, 4);
        pulse_start(3);
        chk("e_done_drop", done_w[3], 0);
        chk("e_busy", busy_w[3], 1);
        chk("e_count0", cnt_w[3], 0);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < k; s++) begin
                tick();
                chk("e_stall_busy", busy_w[3], 1);
                chk("e_stall_count", cnt_w[3], k);
            end
            send(3, d1[k]);
            chk("e_count", cnt_w[3], k + 1);
        end
        wait_done(3);
        // asynchronous abort after two responses, then a clean full run
        gold[3] = 16'h05fa;
        pulse_start(3);
        send(3, d2[0]);
        send(3, d2[1]);
        #2 rst = 1'b1;
        #1;
        chk("f_abort_busy", busy_w[3], 0);
        chk("f_abort_done", done_w[3], 0);
        chk("f_abort_sig", sig_w[3], 16'h0000);
        chk("f_abort_count", cnt_w[3], 0);
        #1 rst = 1'b0;
        tick();
        push(3, 16'h05fa, 1'b1, 4);
        pulse_start(3);
        for (int k = 0; k < 4; k++) send(3, d2[k]);
        wait_done(3);
        tick();
        tick();
        for (int i = 0; i < N; i++) chk($sformatf("pending%0d", i), q[i].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
